// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction front end.
// A small FSM issues one word read at a time to instruction memory
// (req/ack) and pushes each returned word, tagged with its address, into a
// DEPTH-entry in-order queue. Control drains the queue over valid/ready.
// A redirect flushes the queue and squashes any fetch still in flight.
// The memory handshake is never abandoned: a squashed request keeps
// mem_req high until its ack arrives, and the data is then dropped.
module fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     ir_valid,
    output logic [DATA_W-1:0]        ir_data,
    output logic [ADDR_W-1:0]        ir_pc,
    input  logic                     ir_ready,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0]   ir_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   fetch_pc_r;
    logic [ADDR_W-1:0]   req_addr_r;
    logic                mem_req_r;

    logic [DATA_W-1:0]   data_mem_r [DEPTH];
    logic [ADDR_W-1:0]   pc_mem_r   [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                ir_valid_r;

    logic                push_s;
    logic                pop_s;
    logic [CNT_W-1:0]    count_nxt_s;

    // A returning word is queued only for a live (non-squashed) fetch.
    assign push_s = (state_r == BUSY) && mem_ack && !redirect;
    // Head is consumed on a valid/ready handshake.
    assign pop_s  = ir_valid_r && ir_ready;

    // Next occupancy: redirect empties the queue regardless of push/pop.
    always_comb begin
        count_nxt_s = count_r;
        if (redirect) begin
            count_nxt_s = CNT_ZERO;
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Queue storage, pointers, occupancy and registered head-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= {DATA_W{1'b0}};
                pc_mem_r[i]   <= {ADDR_W{1'b0}};
            end
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            ir_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= mem_rdata;
                pc_mem_r[wr_ptr_r]   <= req_addr_r;
            end
            if (redirect) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
            count_r    <= count_nxt_s;
            ir_valid_r <= (count_nxt_s != CNT_ZERO);
        end
    end

    // Fetch FSM: one outstanding request, gated by fetch_en and free space.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= RESET_PC;
            mem_req_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_pc;
                    end else if (fetch_en && (count_r < DEPTH_CNT)) begin
                        req_addr_r <= fetch_pc_r;
                        state_r    <= BUSY;
                        mem_req_r  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                        if (redirect) begin
                            fetch_pc_r <= redirect_pc;
                        end else begin
                            fetch_pc_r <= fetch_pc_r + ADDR_ONE;
                        end
                    end else if (redirect) begin
                        // Squash: keep the handshake alive, drop data on ack.
                        fetch_pc_r <= redirect_pc;
                        state_r    <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_pc;
                    end
                    if (mem_ack) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = req_addr_r;
    assign ir_valid = ir_valid_r;
    assign ir_data  = data_mem_r[rd_ptr_r];
    assign ir_pc    = pc_mem_r[rd_ptr_r];
    assign ir_count = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DATA_W=32, ADDR_W=16, DEPTH=4).
// Memory model acks after a programmable wait (or on demand); a scoreboard
// of expected PCs is checked against every word control consumes.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic [2:0]  ir_count;

    int checks = 0;
    int errors = 0;
    int deliv  = 0;
    int lat    = 0;
    bit mem_hold = 1'b0;
    bit mem_kick = 1'b0;

    logic [15:0] sb[$];
    logic [15:0] req_log[$];

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic [2:0]  cnt;
        logic        vld;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl[18];

    fetch_queue #(.DATA_W(32), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .ir_count(ir_count)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] img(input logic [15:0] a);
        return {a ^ 16'hA5A5, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Memory responder: ack after lat idle cycles, or on kick in hold mode.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (!mem_req) begin
                cnt = 0;
            end else if (mem_hold) begin
                if (mem_kick) begin
                    mem_ack = 1'b1;
                    mem_rdata = img(mem_addr);
                    req_log.push_back(mem_addr);
                    mem_kick = 1'b0;
                end
            end else if (cnt == lat) begin
                mem_ack = 1'b1;
                mem_rdata = img(mem_addr);
                req_log.push_back(mem_addr);
            end else begin
                cnt++;
            end
        end
    end

    // Scoreboard monitor: each consumed head must match the next expected PC.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && ir_valid && ir_ready) begin
                deliv++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(ir_pc), 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", 64'(ir_pc), 64'(e));
                    chk("sb_data", 64'(ir_data), 64'(img(e)));
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; fetch_en = 1'b0; ir_ready = 1'b0; redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'h0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'h0);
        chk({tag, "_ir_valid"}, 64'(ir_valid), 64'h0);
        chk({tag, "_ir_data"}, 64'(ir_data), 64'h0);
        chk({tag, "_ir_pc"}, 64'(ir_pc), 64'h0);
        chk({tag, "_ir_count"}, 64'(ir_count), 64'h0);
    endtask

    task automatic wait_req(input logic v, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (mem_req == v) done = 1'b1;
        end
        chk(name, 64'(done), 64'h1);
    endtask

    task automatic wait_count(input logic [2:0] n, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (ir_count == n) done = 1'b1;
        end
        chk(name, 64'(done), 64'h1);
    endtask

    task automatic wait_valid(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (ir_valid) done = 1'b1;
        end
        chk(name, 64'(done), 64'h1);
    endtask

    task automatic quiesce();
        bit done = 1'b0;
        @(negedge clk);
        fetch_en = 1'b0; ir_ready = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (!mem_req && !ir_valid) done = 1'b1;
        end
        chk("quiesce", 64'(done), 64'h1);
    endtask

    task automatic redirect_idle(input logic [15:0] pc);
        quiesce();
        @(negedge clk);
        redirect = 1'b1; redirect_pc = pc; ir_ready = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        sb.delete();
        req_log.delete();
    endtask

    initial begin
        int d0;
        int maxc;
        logic [15:0] a;

        //                fe    rdy   req   addr      cnt   vld   pc
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b1, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 3'd1, 1'b1, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 3'd2, 1'b1, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 3'd2, 1'b1, 16'h0000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0002, 3'd3, 1'b1, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 3'd3, 1'b1, 16'h0000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 3'd4, 1'b1, 16'h0000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 3'd4, 1'b1, 16'h0000};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 3'd4, 1'b1, 16'h0000};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0003, 3'd3, 1'b1, 16'h0001};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 16'h0004, 3'd2, 1'b1, 16'h0002};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 16'h0004, 3'd2, 1'b1, 16'h0003};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 16'h0005, 3'd1, 1'b1, 16'h0004};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 16'h0005, 3'd1, 1'b1, 16'h0005};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 16'h0006, 3'd0, 1'b0, 16'h0000};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 16'h0006, 3'd1, 1'b1, 16'h0006};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 16'h0007, 3'd0, 1'b0, 16'h0000};

        // Reset values
        reset_dut();
        @(posedge clk); #1;
        chk_reset_outputs("rst");

        // Table: fill to DEPTH with ir_ready low, then drain and resume at 4
        lat = 0;
        for (int i = 0; i < 16; i++) sb.push_back(16'(i));
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            fetch_en = tbl[i].fe;
            ir_ready = tbl[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_req", i), 64'(mem_req), 64'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), 64'(mem_addr), 64'(tbl[i].addr));
            chk($sformatf("tbl%0d_cnt", i), 64'(ir_count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_vld", i), 64'(ir_valid), 64'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_pc", i), 64'(ir_pc), 64'(tbl[i].pc));
        end
        quiesce();

        // Streaming from reset with one-cycle memory latency
        reset_dut();
        sb.delete(); req_log.delete();
        for (int i = 0; i < 64; i++) sb.push_back(16'(i));
        lat = 1;
        d0 = deliv;
        maxc = 0;
        @(negedge clk);
        fetch_en = 1'b1; ir_ready = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (int'(ir_count) > maxc) maxc = int'(ir_count);
        end
        quiesce();
        chk("stream_maxcount", 64'(maxc), 64'h1);
        chk("stream_ndeliv", 64'(deliv - d0), 64'(req_log.size()));
        for (int i = 0; i < req_log.size(); i++)
            chk($sformatf("stream_addr%0d", i), 64'(req_log[i]), 64'(i));

        // PC wrap at 0xFFFF and 10 full fill/drain rounds
        lat = 0;
        redirect_idle(16'hFFFE);
        a = 16'hFFFE;
        for (int i = 0; i < 40; i++) begin
            sb.push_back(a);
            a = a + 16'h0001;
        end
        for (int r = 0; r < 10; r++) begin
            bit done;
            @(negedge clk);
            fetch_en = 1'b1; ir_ready = 1'b0;
            done = 1'b0;
            for (int i = 0; i < 100 && !done; i++) begin
                @(posedge clk); #1;
                if (ir_count == 3'd4 && !mem_req) done = 1'b1;
            end
            chk("wrap_fill", 64'(done), 64'h1);
            @(negedge clk);
            fetch_en = 1'b0; ir_ready = 1'b1;
            done = 1'b0;
            for (int i = 0; i < 100 && !done; i++) begin
                @(posedge clk); #1;
                if (!ir_valid) done = 1'b1;
            end
            chk("wrap_drain", 64'(done), 64'h1);
        end
        chk("wrap_sb_empty", 64'(sb.size()), 64'h0);
        chk("wrap_nreq", 64'(req_log.size()), 64'd40);
        a = 16'hFFFE;
        for (int i = 0; i < req_log.size(); i++) begin
            chk($sformatf("wrap_addr%0d", i), 64'(req_log[i]), 64'(a));
            a = a + 16'h0001;
        end

        // Redirect while the request waits for a slow ack
        lat = 3;
        redirect_idle(16'h0010);
        for (int i = 0; i < 16; i++) sb.push_back(16'h0100 + 16'(i));
        @(negedge clk);
        fetch_en = 1'b1; ir_ready = 1'b1;
        wait_req(1'b1, "rdw_req_rise");
        chk("rdw_addr0", 64'(mem_addr), 64'h0010);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0100;
        @(posedge clk); #1;
        chk("rdw_req_held", 64'(mem_req), 64'h1);
        chk("rdw_addr_held", 64'(mem_addr), 64'h0010);
        @(negedge clk);
        redirect = 1'b0;
        @(posedge clk); #1;
        chk("rdw_addr_held2", 64'(mem_addr), 64'h0010);
        wait_req(1'b0, "rdw_stale_ack");
        chk("rdw_stale_cnt", 64'(ir_count), 64'h0);
        chk("rdw_stale_vld", 64'(ir_valid), 64'h0);
        wait_req(1'b1, "rdw_new_req");
        chk("rdw_new_addr", 64'(mem_addr), 64'h0100);
        wait_valid("rdw_first_valid");
        chk("rdw_first_pc", 64'(ir_pc), 64'h0100);
        quiesce();

        // Redirect coincident with ack and pop, three entries queued
        lat = 0;
        redirect_idle(16'h0030);
        for (int i = 0; i < 16; i++) sb.push_back(16'h0030 + 16'(i));
        @(negedge clk);
        fetch_en = 1'b1; ir_ready = 1'b0;
        wait_count(3'd3, "coin_fill3");
        mem_hold = 1'b1;
        wait_req(1'b1, "coin_req4");
        mem_kick = 1'b1;
        d0 = deliv;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0200; ir_ready = 1'b1;
        @(posedge clk); #1;
        chk("coin_vld", 64'(ir_valid), 64'h0);
        chk("coin_cnt", 64'(ir_count), 64'h0);
        chk("coin_req", 64'(mem_req), 64'h0);
        chk("coin_popped", 64'(deliv - d0), 64'h1);
        sb.delete();
        for (int i = 0; i < 16; i++) sb.push_back(16'h0200 + 16'(i));
        @(negedge clk);
        redirect = 1'b0; mem_hold = 1'b0;
        @(posedge clk); #1;
        chk("coin_new_req", 64'(mem_req), 64'h1);
        chk("coin_new_addr", 64'(mem_addr), 64'h0200);
        wait_valid("coin_first_valid");
        chk("coin_first_pc", 64'(ir_pc), 64'h0200);
        quiesce();

        // Reset one cycle after mem_req rises, with entries queued
        redirect_idle(16'h0050);
        for (int i = 0; i < 16; i++) sb.push_back(16'h0050 + 16'(i));
        @(negedge clk);
        fetch_en = 1'b1; ir_ready = 1'b0;
        wait_count(3'd2, "mrst_fill2");
        mem_hold = 1'b1;
        wait_req(1'b1, "mrst_req");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("mrst");
        @(negedge clk);
        rst = 1'b0; mem_hold = 1'b0; ir_ready = 1'b1;
        sb.delete();
        for (int i = 0; i < 16; i++) sb.push_back(16'(i));
        wait_req(1'b1, "mrst_restart");
        chk("mrst_restart_addr", 64'(mem_addr), 64'h0000);
        wait_valid("mrst_first_valid");
        chk("mrst_first_pc", 64'(ir_pc), 64'h0000);
        quiesce();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch unit with a built-in instruction queue. It generalises the earlier single-register fetch/IR register-file pair into a decoupled front end. It issues word reads to instruction memory over a req/ack handshake and buffers up to DEPTH fetched words with their PCs. It then delivers them in order to control over a valid/ready interface, and supports a redirect (branch/jump) that flushes the queue and any in-flight fetch.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 16, word address width (PC counts words)
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 0, first fetch address after reset
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- fetch_en  input  1  permits new memory requests (does not affect queue output)
- mem_req  output  1  read request, held until mem_ack
- mem_addr  output  ADDR_W  request address, stable while mem_req high
- mem_ack  input  1  one-cycle acknowledge; mem_rdata valid this cycle
- mem_rdata  input  DATA_W  read data
- ir_valid  output  1  queue head valid
- ir_data  output  DATA_W  queue head instruction
- ir_pc  output  ADDR_W  address of queue head
- ir_ready  input  1  control consumes head when ir_valid && ir_ready
- redirect  input  1  one-cycle flush request
- redirect_pc  input  ADDR_W  new fetch address
- ir_count  output  clog2(DEPTH)+1  current number of queued entries

## Operation
- Registers: fetch_pc, req_addr, state, queue storage (DEPTH x {DATA_W, ADDR_W}), wr_ptr, rd_ptr, count.
- Reset: state IDLE, fetch_pc = req_addr = RESET_PC, pointers/count 0, storage cleared; outputs mem_req 0, mem_addr RESET_PC, ir_valid 0, ir_data 0, ir_pc 0, ir_count 0.
- mem_req = (state != IDLE); mem_addr = req_addr; ir_valid = (count != 0); head outputs read from storage[rd_ptr].
- At most one request outstanding.
- FSM:
  - IDLE: redirect -> fetch_pc <= redirect_pc, stay. Else if fetch_en && count < DEPTH -> req_addr <= fetch_pc, go BUSY.
  - BUSY: mem_ack && !redirect -> push {mem_rdata, req_addr}, fetch_pc <= fetch_pc+1, go IDLE. mem_ack && redirect -> drop data, fetch_pc <= redirect_pc, go IDLE. !mem_ack && redirect -> fetch_pc <= redirect_pc, go DISCARD.
  - DISCARD: mem_req stays high with old req_addr (handshake never abandoned). mem_ack -> drop data, go IDLE. redirect here -> fetch_pc <= redirect_pc (last one wins).
- Full gating: request only issued when count < DEPTH. Because one request is outstanding at a time, the queue never overflows. A push is never blocked.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect priority: in the redirect cycle, count, wr_ptr and rd_ptr go to 0 regardless of push/pop. A head consumed in that same cycle is still counted as delivered to control.
- Arithmetic: fetch_pc+1 and pointers wrap modulo 2^ADDR_W / DEPTH. Count saturates by construction (range 0..DEPTH).
- fetch_en low: no new request. An outstanding request still completes and pushes.

## Timing
- Request issue: IDLE with conditions met in cycle N -> mem_req high in N+1.
- Ack in cycle M -> ir_valid high in M+1 (if the queue was empty). Next mem_req is possible at M+2 (one IDLE cycle), giving a peak throughput of 1 word per 2 cycles with zero-wait memory.
- Pop: head advances the cycle after the valid && ready edge. No bubble while count > 1.
- Redirect in cycle R: ir_valid 0 in R+1. The first new request (IDLE path) is at R+2 at the earliest; from DISCARD it is 2 cycles after the stale ack.
- rst mid-transfer: immediate return to reset state; mem_req drops next cycle even if unacknowledged. Memory model must tolerate this.

## Test plan
- Reset, fetch_en=1, memory acks 1 cycle after req, ir_ready=1 -> mem_addr 0,1,2,3…; ir_data/ir_pc pairs match memory image in order; ir_count never exceeds 1.
- ir_ready=0, DEPTH=4 -> exactly 4 requests (addr 0..3), then mem_req stays 0, ir_count=4. Raise ir_ready -> 4 pops, fetching resumes at addr 4.
- Redirect to 0x0100 while waiting for ack (3-cycle memory latency) -> mem_addr holds old value until ack, that data is not queued, next request addr 0x0100, first ir_pc 0x0100.
- Redirect coincident with mem_ack and a pop, queue holding 3 entries -> ir_valid 0 next cycle, ir_count 0, next fetch at redirect_pc.
- fetch_pc = 0xFFFF with ADDR_W=16 -> next request address 0x0000. Queue pointers wrap over 10 full fill/drain cycles with no lost or duplicated entry.
- rst asserted one cycle after mem_req rises -> all outputs at reset values next cycle; fetching restarts at RESET_PC.
